// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared constants and state encoding for the MAC sequencer
package mac_seq_pkg;

    localparam int N_TAPS_DEF = 9;
    localparam int DW_DEF     = 16;
    localparam int ADDR_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        CAPTURE,
        ISSUE,
        WAIT_MAC,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle pulse on a rising edge of a synchronous level
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - walks N_TAPS operand pairs from memory into a MAC, with single-step support
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic              step_mode,
    input  logic              press,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DW-1:0]     rd_data,
    input  logic [DW-1:0]     rd_weight,
    output logic              mac_clr,
    output logic              mac_valid,
    output logic [DW-1:0]     mac_a,
    output logic [DW-1:0]     mac_b,
    input  logic              mac_ready,
    input  logic              mac_done,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] tap_idx,
    output logic [DW-1:0]     disp_val
);

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic              press_rise;

    // The edge history runs continuously, so a press that rose before HOLD has already spent its pulse.
    rise_detect u_press_rise (
        .Clock   (Clock),
        .Reset   (Reset),
        .level_i (press),
        .pulse_o (press_rise)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        a_d       = a_q;
        b_d       = b_q;
        disp_d    = disp_q;
        rd_en     = 1'b0;
        mac_clr   = 1'b0;
        mac_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = CLEAR;
                    tap_d   = '0;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                a_d     = rd_data;
                b_d     = rd_weight;
                disp_d  = rd_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                mac_valid = 1'b1;
                if (mac_ready) begin
                    state_d = WAIT_MAC;
                end
            end
            WAIT_MAC: begin
                if (mac_done) begin
                    if (tap_q == LAST_TAP) begin
                        state_d = DONE;
                    end else begin
                        tap_d   = tap_q + 1'b1;
                        state_d = step_mode ? HOLD : FETCH;
                    end
                end
            end
            HOLD: begin
                if (press_rise) begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks every other event of the cycle and suppresses the handshake and done at once.
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            tap_d     = '0;
            mac_valid = 1'b0;
            done      = 1'b0;
        end
    end

    assign rd_addr  = tap_q;
    assign tap_idx  = tap_q;
    assign mac_a    = a_q;
    assign mac_b    = b_q;
    assign disp_val = disp_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter N_TAPS, default 9, giving the data/weight pairs per dot product (legal 2..15).
REQ-002 SHALL have parameter DW, default 16, giving the operand width.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a run.
REQ-006 SHALL have port abort, input, 1 bit: terminates a run.
REQ-007 SHALL have port step_mode, input, 1 bit: 1 means advance one tap per press.
REQ-008 SHALL have port press, input, 1 bit: step button, pre-synchronised level.
REQ-009 SHALL have ports rd_en (output, 1) and rd_addr (output, 4): operand memory read request and address.
REQ-010 SHALL have ports rd_data (input, DW) and rd_weight (input, DW): data and weight, valid exactly one cycle after rd_en.
REQ-011 SHALL have port mac_clr, output, 1 bit: clears the MAC accumulator.
REQ-012 SHALL have ports mac_valid (output, 1), mac_a (output, DW) and mac_b (output, DW): operand handshake to the MAC.
REQ-013 SHALL have ports mac_ready (input, 1) and mac_done (input, 1): MAC accepts operands, and MAC finished the accumulate.
REQ-014 SHALL have ports busy (output, 1), done (output, 1), tap_idx (output, 4) and disp_val (output, DW): status, plus the last operand for the 7-segment display.

Function
REQ-015 SHALL implement states IDLE, CLEAR, FETCH, CAPTURE, ISSUE, WAIT_MAC, HOLD and DONE.
REQ-016 IDLE: start=1 and abort=0 SHALL go to CLEAR; tap_idx=0; busy=0.
REQ-017 CLEAR: mac_clr SHALL be high for exactly this one cycle, then go to FETCH.
REQ-018 FETCH: rd_en=1 and rd_addr=tap_idx for one cycle, then go to CAPTURE.
REQ-019 CAPTURE: SHALL register rd_data into mac_a, rd_weight into mac_b and rd_data into disp_val, then go to ISSUE.
REQ-020 ISSUE: mac_valid SHALL be high, with mac_a/mac_b stable, until a cycle where mac_valid and mac_ready are both high (transfer), then go to WAIT_MAC.
REQ-021 WAIT_MAC: on mac_done=1, if tap_idx=N_TAPS-1 go to DONE; else increment tap_idx and go to HOLD if step_mode=1, otherwise FETCH.
REQ-022 HOLD: SHALL go to FETCH only on a press rising edge detected while in HOLD; a press already high on entry SHALL NOT advance.
REQ-023 DONE: done SHALL be high for exactly one cycle, then go to IDLE; tap_idx SHALL hold N_TAPS-1 until the next start.
REQ-024 busy SHALL equal 1 in every state except IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, drop mac_valid, and never pulse done.
REQ-027 abort SHALL win over start, mac_done and press edges sampled in the same cycle.
REQ-028 mac_done SHALL be ignored outside WAIT_MAC; mac_ready SHALL be ignored outside ISSUE.
REQ-029 Throughput with mac_ready=1 and mac_done asserted on WAIT_MAC entry: 4 cycles per tap, and done 4*N_TAPS+2 cycles after start is sampled.
REQ-030 step_mode SHALL be sampled only in WAIT_MAC, so it may change mid-run.

Reset
REQ-031 Reset=0 SHALL asynchronously force IDLE, with tap_idx=0, mac_a=mac_b=disp_val=0, all 1-bit outputs 0, and the press-edge history cleared to 0.
REQ-032 Reset asserted mid-run SHALL leave no pending done, clear or valid after release; the first edge after release is in IDLE.

Structure
REQ-033 Package mac_seq_pkg SHALL hold the state encoding, the N_TAPS/DW defaults and the 4-bit address width constant.
REQ-034 SHALL instantiate one sub-module, rise_detect (Clock, Reset, level in, 1-cycle pulse out), for press.

Verification
REQ-035 SHALL cover: N_TAPS=9, mac_ready=1, mac_done on WAIT_MAC entry, start at cycle 0 -> mac_clr at cycle 1, rd_addr 0..8 in order, done at cycle 38 only.
REQ-036 SHALL cover: memory entries 0..8 = 16'hB78E/16'h0002, mac_ready low 3 cycles per tap -> mac_a/mac_b stable while valid, 9 transfers, disp_val=16'hB78E.
REQ-037 SHALL cover: step_mode=1 with press held high into HOLD -> no advance; release then press -> exactly one tap advances.
REQ-038 SHALL cover: abort coincident with mac_done at tap 4 -> IDLE next cycle, done never asserted, a new start runs from tap 0.
REQ-039 SHALL cover: Reset low during ISSUE at tap 6 -> all outputs 0 immediately (asynchronous), busy=0 after release.
REQ-040 SHALL cover: start pulsed at taps 2 and 5 while busy -> ignored, run completes normally with a single done.
